pattern_hist_engine: RTL
========================

PATTERN_HIST_ENGINE -- requirements
Module: pattern_hist_engine

Interface
REQ-001 Parameter BASE_ADDR, default 32: first data_mem address scanned.
REQ-002 Parameter COUNT, default 64: number of bytes scanned, legal 1..255.
REQ-003 Parameter PAT_ADDR, default 9: data_mem address whose bits [3:0] hold the 4-bit pattern.
REQ-004 Parameter OUT_ADDR, default 10: first of five consecutive histogram result addresses.
REQ-005 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  sampled high in IDLE or DONE: launch one scan.
REQ-008 halt  output  1  high while in DONE: results written.
REQ-009 mem_addr  output  8  data_mem address for the read or write.
REQ-010 mem_rd_data  input  8  data_mem read data, valid one cycle after mem_addr is driven.
REQ-011 mem_wr_en  output  1  data_mem write strobe; write occurs on the rising edge.
REQ-012 mem_wr_data  output  8  data_mem write data.

Function
REQ-013 FSM states SHALL be IDLE, READ_PAT, SCAN, DRAIN, WRITE, DONE.
REQ-014 IDLE or DONE with start=1 -> READ_PAT: clear bins 1..5 and the scan index.
REQ-015 IDLE or DONE with start=0 -> remain in the current state.
REQ-016 READ_PAT: exactly 1 cycle; mem_addr=PAT_ADDR; next state SCAN.
REQ-017 SCAN: COUNT cycles; cycle i drives mem_addr=BASE_ADDR+i (8-bit wrap).
REQ-018 SCAN pattern capture: cycle 0 captures mem_rd_data[3:0] as the pattern; no byte is classified that cycle.
REQ-019 SCAN classification: cycle i>0 classifies the byte returned from address BASE_ADDR+i-1.
REQ-020 DRAIN: 1 cycle; classifies the last byte (BASE_ADDR+COUNT-1); next state WRITE.
REQ-021 Classification: m = count of windows [7:4],[6:3],[5:2],[4:1],[3:0] equal to the pattern, range 0..5.
REQ-022 Bin update: m>=1 increments 8-bit bin m; m=0 changes no bin.
REQ-023 WRITE: 5 cycles; cycle k (0..4): mem_wr_en=1, mem_addr=OUT_ADDR+k, mem_wr_data=bin k+1; then DONE.
REQ-024 mem_wr_en SHALL be 0 in every state other than WRITE.
REQ-025 halt=1 only in DONE; it rises on the (COUNT+7)th rising edge after the edge that sampled start (71 for COUNT=64).
REQ-026 start asserted in READ_PAT, SCAN, DRAIN or WRITE SHALL be ignored.
REQ-027 Bins SHALL NOT accumulate across runs; each launch starts from zero.
REQ-028 Pattern address SHALL NOT be re-read during SCAN; a pattern change mid-run affects only the next run.

Reset
REQ-029 Reset=1 at an edge: state IDLE, halt=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, bins=0, pattern=0, index=0.
REQ-030 Reset SHALL take priority over start and apply in any state, including mid-SCAN and mid-WRITE, with no further writes.
REQ-031 Reset held high with start high SHALL keep the block in IDLE.

Verification
REQ-032 Pattern 0010, mem[32..95]=0x00, pulse start -> mem[10..14]=0,0,0,0,0 written; halt rises 71 edges after start sampled.
REQ-033 Pattern 0000, all bytes 0x00 -> every byte m=5 -> mem[10..14]=0,0,0,0,64.
REQ-034 Pattern 0010, all bytes 0x22 (windows [7:4] and [3:0] match) -> mem[10..14]=0,64,0,0,0.
REQ-035 Pattern 0010, mem[32]=0x20, mem[33]=0x22, rest 0x00 -> mem[10..14]=1,1,0,0,0; mem_wr_en high exactly 5 cycles.
REQ-036 Reset pulsed during SCAN cycle 20 -> halt=0 and mem_wr_en never asserts; a new start then gives the correct histogram.
REQ-037 Two back-to-back runs, start re-pulsed in DONE with the REQ-034 data -> second result 0,64,0,0,0, not 0,128,0,0,0.

Source files
------------

// File: rtl/pattern_hist_engine.sv
// Pattern histogram engine: reads a 4-bit pattern, scans COUNT bytes of data memory,
// counts how many 4-bit windows of each byte match the pattern and writes a five-bin
// histogram (bins 1..5 by match count) back to memory.
module pattern_hist_engine #(
  parameter int unsigned BASE_ADDR = 32,
  parameter int unsigned COUNT     = 64,
  parameter int unsigned PAT_ADDR  = 9,
  parameter int unsigned OUT_ADDR  = 10
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  output logic       halt,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  localparam logic [7:0] BaseA   = 8'(BASE_ADDR);
  localparam logic [7:0] LastIdx = 8'(COUNT - 1);
  localparam logic [7:0] PatA    = 8'(PAT_ADDR);
  localparam logic [7:0] OutA    = 8'(OUT_ADDR);

  typedef enum logic [2:0] {
    StIdle, StReadPat, StScan, StDrain, StWrite, StDone
  } state_e;

  state_e      state_q;
  logic [7:0]  idx_q;
  logic [2:0]  wr_k_q;
  logic [3:0]  pat_q;
  logic [7:0]  bins_q [5];
  logic [7:0]  bins_d [5];
  logic [2:0]  match_cnt;
  logic        classify;

  // Count matching windows of the returned byte and form the updated bins.
  always_comb begin
    match_cnt = 3'd0;
    for (int s = 0; s < 5; s++) begin
      if (mem_rd_data[s +: 4] == pat_q) match_cnt = match_cnt + 3'd1;
    end
    // Scan cycle 0 returns the pattern byte, not data.
    classify = ((state_q == StScan) && (idx_q != 8'd0)) || (state_q == StDrain);
    for (int j = 0; j < 5; j++) begin
      bins_d[j] = bins_q[j] + ((classify && (match_cnt == 3'(j + 1))) ? 8'd1 : 8'd0);
    end
  end

  // Control FSM with registered memory-side outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= StIdle;
      idx_q       <= 8'd0;
      wr_k_q      <= 3'd0;
      pat_q       <= 4'd0;
      halt        <= 1'b0;
      mem_addr    <= 8'd0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'd0;
      for (int j = 0; j < 5; j++) bins_q[j] <= 8'd0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StReadPat;
            halt      <= 1'b0;
            mem_addr  <= PatA;
            mem_wr_en <= 1'b0;
            idx_q     <= 8'd0;
            for (int j = 0; j < 5; j++) bins_q[j] <= 8'd0;
          end
        end
        StReadPat: begin
          state_q  <= StScan;
          mem_addr <= BaseA;
          idx_q    <= 8'd0;
        end
        StScan: begin
          for (int j = 0; j < 5; j++) bins_q[j] <= bins_d[j];
          if (idx_q == 8'd0) pat_q <= mem_rd_data[3:0];
          if (idx_q == LastIdx) begin
            state_q <= StDrain;
          end else begin
            idx_q    <= idx_q + 8'd1;
            mem_addr <= BaseA + idx_q + 8'd1;
          end
        end
        StDrain: begin
          // First write carries bin 1 including the last byte's contribution.
          for (int j = 0; j < 5; j++) bins_q[j] <= bins_d[j];
          state_q     <= StWrite;
          wr_k_q      <= 3'd0;
          mem_wr_en   <= 1'b1;
          mem_addr    <= OutA;
          mem_wr_data <= bins_d[0];
        end
        StWrite: begin
          if (wr_k_q == 3'd4) begin
            state_q   <= StDone;
            halt      <= 1'b1;
            mem_wr_en <= 1'b0;
          end else begin
            wr_k_q      <= wr_k_q + 3'd1;
            mem_addr    <= OutA + {5'd0, wr_k_q} + 8'd1;
            mem_wr_data <= bins_q[wr_k_q + 3'd1];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
